// File: rtl/de_hazard_stage.sv
// de_hazard_stage: RV32I decode stage with register file, busy-bit
// scoreboard and RAW/WAW hazard stall toward fetch.
// Optional feature: define WB_BYPASS_EN to forward same-cycle writeback
// data into decode and to treat that source as already available.
module de_hazard_stage #(
  parameter int DBITS = 32,
  parameter int REGS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32+3*DBITS:0]   fe_latch_in,
  input  logic                  br_taken,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [DBITS-1:0]      wb_data,
  output logic                  stall_to_fe,
  output logic [10+6*DBITS:0]   de_latch_out
);

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'd0,
    OP_ALU_I   = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_JAL     = 4'd5,
    OP_JALR    = 4'd6,
    OP_LUI     = 4'd7,
    OP_AUIPC   = 4'd8,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef struct packed {
    logic             valid;
    logic [31:0]      inst;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pcplus;
    logic [DBITS-1:0] inst_count;
  } fe_t;

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [DBITS-1:0] rs1val;
    logic [DBITS-1:0] rs2val;
    logic [DBITS-1:0] imm;
    logic [4:0]       rd;
    logic             wr_en;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pcplus;
    logic [DBITS-1:0] inst_count;
  } de_t;

  fe_t              fe;
  de_t              de_d, de_q;
  logic [DBITS-1:0] rf [REGS];
  logic [REGS-1:0]  busy, busy_nxt;

  logic [6:0]       opc, funct7;
  logic [2:0]       f3;
  logic [4:0]       rs1, rs2, rd;
  op_e              op;
  logic             use_rs1, use_rs2, writes, wr_en;
  logic [31:0]      imm32;
  logic             byp1, byp2;
  logic [DBITS-1:0] rs1_val, rs2_val;
  logic             rs1_busy, rs2_busy, rd_busy, hazard, issue;

  assign fe     = fe_t'(fe_latch_in);
  assign opc    = fe.inst[6:0];
  assign f3     = fe.inst[14:12];
  assign funct7 = fe.inst[31:25];
  assign rs1    = fe.inst[19:15];
  assign rs2    = fe.inst[24:20];
  assign rd     = fe.inst[11:7];

  // Opcode/funct decode into op class, operand usage and immediate.
  always_comb begin
    op      = OP_ILLEGAL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writes  = 1'b0;
    imm32   = '0;
    case (opc)
      7'b0110011: if (funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
        op = OP_ALU_R; use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1;
      end
      7'b0010011: if (!(f3 == 3'b001 && funct7 != 7'h00) &&
                      !(f3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
        op = OP_ALU_I; use_rs1 = 1'b1; writes = 1'b1;
      end
      7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
        op = OP_LOAD; use_rs1 = 1'b1; writes = 1'b1;
      end
      7'b0100011: if (f3 < 3'b011) begin
        op = OP_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        op = OP_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1101111: begin op = OP_JAL; writes = 1'b1; end
      7'b1100111: if (f3 == 3'b000) begin
        op = OP_JALR; use_rs1 = 1'b1; writes = 1'b1;
      end
      7'b0110111: begin op = OP_LUI;   writes = 1'b1; end
      7'b0010111: begin op = OP_AUIPC; writes = 1'b1; end
      default:    op = OP_ILLEGAL;
    endcase

    case (op)
      OP_ALU_I, OP_LOAD, OP_JALR:
        imm32 = {{20{fe.inst[31]}}, fe.inst[31:20]};
      OP_STORE:
        imm32 = {{20{fe.inst[31]}}, fe.inst[31:25], fe.inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{fe.inst[31]}}, fe.inst[31], fe.inst[7], fe.inst[30:25],
                 fe.inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {fe.inst[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{fe.inst[31]}}, fe.inst[31], fe.inst[19:12], fe.inst[20],
                 fe.inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign wr_en = writes && (rd != 5'd0);

`ifdef WB_BYPASS_EN
  assign byp1 = wb_we && (wb_rd == rs1) && (rs1 != 5'd0);
  assign byp2 = wb_we && (wb_rd == rs2) && (rs2 != 5'd0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Operand read: x0 reads zero, optional forward from the writeback port.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
    if (byp1) rs1_val = wb_data;
    if (byp2) rs2_val = wb_data;
  end

  // Hazard detect. The destination is free if its old producer retires
  // this cycle: the new busy set lands on the same edge and wins.
  always_comb begin
    rs1_busy    = busy[rs1] && !byp1;
    rs2_busy    = busy[rs2] && !byp2;
    rd_busy     = busy[rd] && !(wb_we && (wb_rd == rd));
    hazard      = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy) ||
                  (wr_en && rd_busy);
    stall_to_fe = reset && fe.valid && !br_taken && hazard;
    issue       = fe.valid && !br_taken && !stall_to_fe && wr_en;
  end

  // Build the decoded latch image; invalid fetch becomes an all-zero bubble.
  always_comb begin
    de_d = '0;
    if (fe.valid) begin
      de_d.valid      = 1'b1;
      de_d.op         = op;
      de_d.rs1val     = use_rs1 ? rs1_val : '0;
      de_d.rs2val     = use_rs2 ? rs2_val : '0;
      de_d.imm        = DBITS'($signed(imm32));
      de_d.rd         = writes ? rd : 5'd0;
      de_d.wr_en      = wr_en;
      de_d.pc         = fe.pc;
      de_d.pcplus     = fe.pcplus;
      de_d.inst_count = fe.inst_count;
    end
  end

  // Scoreboard update: clear on writeback, then set for the issuing producer.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_rd] = 1'b0;
    if (issue) busy_nxt[rd]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Decode latch: flush or stall inject a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        de_q <= '0;
    else if (br_taken || stall_to_fe)  de_q <= '0;
    else                               de_q <= de_d;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign de_latch_out = de_q;

endmodule

// File: doc/de_hazard_stage.md
DE_HAZARD_STAGE -- requirements
Module: de_hazard_stage

Interface
REQ-001 SHALL have parameter DBITS, default 32, data/PC/instruction-count width.
REQ-002 SHALL have parameter REGS, default 32, architectural register count (x0 hardwired zero).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fe_latch_in  input  129  {valid, inst[31:0], pc, pcplus, inst_count}, MSB first.
REQ-006 SHALL have port br_taken  input  1  AGEX redirect; squash the instruction now in decode.
REQ-007 SHALL have ports wb_we  input  1, wb_rd  input  5, wb_data  input  DBITS: writeback port.
REQ-008 SHALL have port stall_to_fe  output  1  hold FE PC and FE latch.
REQ-009 SHALL have port de_latch_out  output  203  {valid, op[3:0], rs1val, rs2val, imm, rd[4:0], wr_en, pc, pcplus, inst_count}, MSB first.

Function
REQ-010 SHALL decode RV32I opcodes into op: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 15 ILLEGAL.
REQ-011 SHALL produce imm sign-extended to DBITS per format I/S/B/U/J; imm = 0 for ALU_R and ILLEGAL.
REQ-012 SHALL set wr_en = 1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC with rd != 0; otherwise 0.
REQ-013 SHALL hold an internal REGS x DBITS register file written at the clock edge when wb_we = 1 and wb_rd != 0; x0 SHALL read 0.
REQ-014 SHALL keep a scoreboard busy[31:1]; busy[0] SHALL be constant 0.
REQ-015 SHALL assert stall_to_fe combinationally when FE valid = 1, br_taken = 0, and any used source (rs1 and/or rs2 per op) or, if wr_en, rd is busy (RAW and WAW).
REQ-016 SHALL, on each edge with br_taken = 0 and stall_to_fe = 0, load de_latch_out from the decoded FE latch (one-cycle latency) and set busy[rd] when valid and wr_en.
REQ-017 SHALL, on each edge with stall_to_fe = 1, load a bubble (all-zero) into de_latch_out and not set busy.
REQ-018 SHALL, on each edge with br_taken = 1, load a bubble, not set busy, and force stall_to_fe = 0 (flush outranks stall).
REQ-019 SHALL clear busy[wb_rd] on each edge with wb_we = 1; when set and clear target the same register in one edge, set SHALL win.
REQ-020 SHALL pass FE valid = 0 through as a bubble without stall and without scoreboard change.
REQ-021 SHALL never let a single register hold more than one outstanding producer (guaranteed by REQ-015 WAW check).

Reset
REQ-022 SHALL, while reset = 0, asynchronously clear de_latch_out to all-zero, busy to all-zero, and all register-file entries to 0.
REQ-023 SHALL drive stall_to_fe = 0 while reset = 0; reset asserted mid-stall SHALL drop the stalled instruction.
REQ-024 SHALL resume normal decode on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with WB_BYPASS_EN defined, forward wb_data to rs1val/rs2val when wb_we = 1 and wb_rd equals the source (nonzero), and treat that source as not busy in the same cycle.
REQ-026 SHALL, without WB_BYPASS_EN, ignore same-cycle writeback for reads: the dependent instruction stalls until the edge after the write, then reads the register file.

Verification
REQ-027 SHALL cover: reset release, FE "addi x1,x0,5" (0x00500093) -> next cycle de_latch_out valid=1, op=1, imm=5, rd=1, wr_en=1, busy[1]=1.
REQ-028 SHALL cover: "add x2,x1,x1" following REQ-027 with no writeback -> stall_to_fe=1, bubble in de_latch_out each cycle; wb_we=1, wb_rd=1, wb_data=5 -> with WB_BYPASS_EN decode same cycle rs1val=rs2val=5; without it, decode one cycle later with 5.
REQ-029 SHALL cover: br_taken=1 while stall_to_fe would be 1 -> stall_to_fe=0, bubble latched, busy unchanged.
REQ-030 SHALL cover: writeback clear and new-producer set for x3 on the same edge -> busy[3]=1 afterwards.
REQ-031 SHALL cover: "addi x0,x0,1" -> wr_en=0, no busy bit set, following "add x4,x0,x0" never stalls, rs1val=0.
REQ-032 SHALL cover: reset asserted during stall -> de_latch_out, busy cleared immediately without clock; stall_to_fe=0.
